riscv_ex_ctrl: RTL and testbench
================================

// Module: riscv_ex_ctrl
// PURPOSE
//  Execute-stage controller for the 5-stage RISC-V pipeline. Drives the EX forwarding selects,
//  detects load-use hazards, sequences branch/jump flushes and holds the pipe while a multi-cycle
//  EX operation (mul/div unit) runs. Sits beside riscv_EX; drives all pipeline-register enables/flushes.
// PARAMETERS
//  FLUSH_CYC   2    cycles IF/ID flush is held after a taken redirect (>=1; covers fetch latency)
//  MC_TIMEOUT  64   max MCWAIT cycles before forced release (>=2)
//  CNT_W       32   width of saturating performance counters
// PORTS
//  i_clk           in   1      clock, rising edge
//  i_rst           in   1      asynchronous reset, active-high
//  i_ID_rs1        in   5      rs1 of instruction in ID
//  i_ID_rs2        in   5      rs2 of instruction in ID
//  i_EX_rs1        in   5      rs1 of instruction in EX
//  i_EX_rs2        in   5      rs2 of instruction in EX
//  i_EX_rd         in   5      rd of instruction in EX
//  i_EX_src_rd     in   2      EX writeback source; 2'b01 = load (memory)
//  i_EX_src_pc     in   2      EX next-PC select; !=0 means taken branch/jump redirect
//  i_EX_mc_req     in   1      instruction in EX is multi-cycle
//  i_EX_mc_done    in   1      multi-cycle unit result valid (1-cycle pulse)
//  i_MEM_reg_wr_en in   1      MEM-stage register write enable
//  i_MEM_rd        in   5      MEM-stage rd
//  i_WB_reg_wr_en  in   1      WB-stage register write enable
//  i_WB_rd         in   5      WB-stage rd
//  o_EX_fwd_sel_a  out  2      0 rs1_data, 1 MEM alu_out, 2 WB rd_data
//  o_EX_fwd_sel_b  out  2      same encoding for rs2
//  o_pc_wr_en      out  1      PC register enable
//  o_IF_ID_wr_en   out  1      IF/ID register enable
//  o_IF_ID_flush   out  1      IF/ID clear to NOP
//  o_ID_EX_wr_en   out  1      ID/EX register enable
//  o_ID_EX_flush   out  1      ID/EX clear to NOP (bubble)
//  o_EX_MEM_flush  out  1      EX/MEM clear to NOP
//  o_mc_timeout    out  1      1-cycle pulse: MCWAIT hit MC_TIMEOUT
//  o_stall_cnt     out  CNT_W  saturating count of stall cycles (load-use + MCWAIT)
//  o_flush_cnt     out  CNT_W  saturating count of redirects taken
// BEHAVIOUR
//  Forwarding (combinational): sel_a=1 if MEM_reg_wr_en & MEM_rd!=0 & MEM_rd==EX_rs1; else 2 if
//   WB_reg_wr_en & WB_rd!=0 & WB_rd==EX_rs1; else 0. MEM has priority over WB. sel_b same with EX_rs2.
//  Load-use hazard LU = (EX_src_rd==2'b01) & EX_rd!=0 & (EX_rd==ID_rs1 | EX_rd==ID_rs2).
//  Default outputs: pc/IF_ID/ID_EX wr_en=1, all flushes=0.
//  FSM states RUN, FLUSH, MCWAIT; priority per cycle: redirect > mc_req > LU.
//  RUN: src_pc!=0 -> IF_ID_flush=1, ID_EX_flush=1 this cycle; flush_cnt++; if FLUSH_CYC>1 go FLUSH
//   with cnt=FLUSH_CYC-1. mc_req (no redirect) -> pc/IF_ID/ID_EX wr_en=0, EX_MEM_flush=1, go MCWAIT,
//   wait cnt=1. LU (neither above) -> pc/IF_ID wr_en=0, ID_EX_flush=1 for exactly 1 cycle, stay RUN.
//  FLUSH: IF_ID_flush=1, pc_wr_en=1; cnt-- each cycle; cnt==1 -> RUN. Redirect seen in FLUSH
//   (cannot be a real instruction) is ignored. LU/mc_req ignored (ID/EX holds NOPs).
//  MCWAIT: pc/IF_ID/ID_EX wr_en=0, EX_MEM_flush=1, stall_cnt++ each cycle. mc_done -> release this
//   cycle (default outputs, EX result latched into EX/MEM), next RUN. cnt==MC_TIMEOUT without done ->
//   o_mc_timeout=1 and release identically, next RUN. mc_done while in RUN is ignored.
//  Entry cycle into MCWAIT and each LU cycle also count in stall_cnt. Counters saturate at all-ones.
//  Reset (async, any state): state=RUN, counters=0, o_mc_timeout=0; while i_rst=1 all wr_en=0,
//   all flushes=1, fwd_sel=0. First cycle after deassert: default outputs.
//  Regs: state, 7-bit wait/flush counter (max(FLUSH_CYC,MC_TIMEOUT) must fit), perf counters.
// TESTING
//  1 MEM rd=5 wr, WB rd=5 wr, EX_rs1=5 -> sel_a=1; MEM rd=0 wr, WB rd=0 -> sel_a=0; EX_rs2=WB_rd=7 -> sel_b=2.
//  2 EX load rd=3, ID rs2=3 -> one cycle pc/IF_ID wr_en=0, ID_EX_flush=1; next cycle defaults; stall_cnt=1.
//  3 src_pc=1 in RUN, FLUSH_CYC=2 -> IF_ID_flush=1 two cycles, ID_EX_flush=1 first only; flush_cnt=1.
//  4 mc_req=1, mc_done after 5 cycles -> stall 5 cycles + release cycle, EX_MEM_flush=1 while waiting;
//    redirect + mc_req same cycle -> redirect wins, no MCWAIT.
//  5 mc_req=1, no done, MC_TIMEOUT=64 -> o_mc_timeout pulse at wait cycle 64, then RUN.
//  6 i_rst asserted mid-MCWAIT -> immediate RUN, counters 0, flush outputs 1 until deassert.

Source files
------------

// File: rtl/riscv_ex_ctrl.sv
// Execute-stage controller: EX operand forwarding, load-use stall, redirect
// flush sequencing and multi-cycle (mul/div) hold with timeout, plus
// saturating stall/flush performance counters.
module riscv_ex_ctrl #(
    parameter int FLUSH_CYC  = 2,
    parameter int MC_TIMEOUT = 64,
    parameter int CNT_W      = 32
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [4:0]       i_ID_rs1,
    input  logic [4:0]       i_ID_rs2,
    input  logic [4:0]       i_EX_rs1,
    input  logic [4:0]       i_EX_rs2,
    input  logic [4:0]       i_EX_rd,
    input  logic [1:0]       i_EX_src_rd,
    input  logic [1:0]       i_EX_src_pc,
    input  logic             i_EX_mc_req,
    input  logic             i_EX_mc_done,
    input  logic             i_MEM_reg_wr_en,
    input  logic [4:0]       i_MEM_rd,
    input  logic             i_WB_reg_wr_en,
    input  logic [4:0]       i_WB_rd,
    output logic [1:0]       o_EX_fwd_sel_a,
    output logic [1:0]       o_EX_fwd_sel_b,
    output logic             o_pc_wr_en,
    output logic             o_IF_ID_wr_en,
    output logic             o_IF_ID_flush,
    output logic             o_ID_EX_wr_en,
    output logic             o_ID_EX_flush,
    output logic             o_EX_MEM_flush,
    output logic             o_mc_timeout,
    output logic [CNT_W-1:0] o_stall_cnt,
    output logic [CNT_W-1:0] o_flush_cnt
);

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_FLUSH  = 2'd1,
        ST_MCWAIT = 2'd2
    } state_t;

    localparam logic [1:0] SRC_LOAD     = 2'b01;
    localparam logic [6:0] FLUSH_RELOAD = 7'(FLUSH_CYC - 1);
    localparam logic [6:0] WAIT_LIMIT   = 7'(MC_TIMEOUT);

    state_t     state, next_state;
    logic [6:0] cnt, next_cnt;
    logic       stall_inc;
    logic       flush_inc;
    logic       load_use;

    assign load_use = (i_EX_src_rd == SRC_LOAD) && (i_EX_rd != 5'd0) &&
                      ((i_EX_rd == i_ID_rs1) || (i_EX_rd == i_ID_rs2));

    // Forwarding selects: MEM result is younger than WB, so it wins.
    always_comb begin
        o_EX_fwd_sel_a = 2'd0;
        o_EX_fwd_sel_b = 2'd0;
        if (!i_rst) begin
            if (i_MEM_reg_wr_en && i_MEM_rd != 5'd0 && i_MEM_rd == i_EX_rs1)
                o_EX_fwd_sel_a = 2'd1;
            else if (i_WB_reg_wr_en && i_WB_rd != 5'd0 && i_WB_rd == i_EX_rs1)
                o_EX_fwd_sel_a = 2'd2;
            if (i_MEM_reg_wr_en && i_MEM_rd != 5'd0 && i_MEM_rd == i_EX_rs2)
                o_EX_fwd_sel_b = 2'd1;
            else if (i_WB_reg_wr_en && i_WB_rd != 5'd0 && i_WB_rd == i_EX_rs2)
                o_EX_fwd_sel_b = 2'd2;
        end
    end

    // Next-state and pipeline-control decode; priority redirect > mc_req > load-use.
    always_comb begin
        // NOTE: every output and next-state term gets a default first so no path infers a latch.
        next_state     = state;
        next_cnt       = cnt;
        stall_inc      = 1'b0;
        flush_inc      = 1'b0;
        o_pc_wr_en     = 1'b1;
        o_IF_ID_wr_en  = 1'b1;
        o_IF_ID_flush  = 1'b0;
        o_ID_EX_wr_en  = 1'b1;
        o_ID_EX_flush  = 1'b0;
        o_EX_MEM_flush = 1'b0;
        o_mc_timeout   = 1'b0;

        case (state)
            ST_RUN: begin
                if (i_EX_src_pc != 2'b00) begin
                    o_IF_ID_flush = 1'b1;
                    o_ID_EX_flush = 1'b1;
                    flush_inc     = 1'b1;
                    if (FLUSH_CYC > 1) begin
                        next_state = ST_FLUSH;
                        next_cnt   = FLUSH_RELOAD;
                    end
                end else if (i_EX_mc_req) begin
                    o_pc_wr_en     = 1'b0;
                    o_IF_ID_wr_en  = 1'b0;
                    o_ID_EX_wr_en  = 1'b0;
                    o_EX_MEM_flush = 1'b1;
                    stall_inc      = 1'b1;
                    next_state     = ST_MCWAIT;
                    next_cnt       = 7'd1;
                end else if (load_use) begin
                    o_pc_wr_en    = 1'b0;
                    o_IF_ID_wr_en = 1'b0;
                    o_ID_EX_flush = 1'b1;
                    stall_inc     = 1'b1;
                end
            end
            ST_FLUSH: begin
                // Fetch is still returning wrong-path words; EX holds NOPs so
                // redirect, mc_req and load-use are all meaningless here.
                o_IF_ID_flush = 1'b1;
                if (cnt <= 7'd1) next_state = ST_RUN;
                else             next_cnt   = cnt - 7'd1;
            end
            ST_MCWAIT: begin
                if (i_EX_mc_done) begin
                    next_state = ST_RUN;
                end else if (cnt == WAIT_LIMIT) begin
                    o_mc_timeout = 1'b1;
                    next_state   = ST_RUN;
                end else begin
                    o_pc_wr_en     = 1'b0;
                    o_IF_ID_wr_en  = 1'b0;
                    o_ID_EX_wr_en  = 1'b0;
                    o_EX_MEM_flush = 1'b1;
                    stall_inc      = 1'b1;
                    next_cnt       = cnt + 7'd1;
                end
            end
            default: next_state = ST_RUN;
        endcase

        // Reset holds every pipeline register cleared and frozen.
        if (i_rst) begin
            o_pc_wr_en     = 1'b0;
            o_IF_ID_wr_en  = 1'b0;
            o_ID_EX_wr_en  = 1'b0;
            o_IF_ID_flush  = 1'b1;
            o_ID_EX_flush  = 1'b1;
            o_EX_MEM_flush = 1'b1;
            o_mc_timeout   = 1'b0;
        end
    end

    // State, wait/flush counter and saturating performance counters.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state       <= ST_RUN;
            cnt         <= 7'd0;
            o_stall_cnt <= '0;
            o_flush_cnt <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            state <= next_state;
            cnt   <= next_cnt;
            if (stall_inc && o_stall_cnt != '1) o_stall_cnt <= o_stall_cnt + CNT_W'(1);
            if (flush_inc && o_flush_cnt != '1) o_flush_cnt <= o_flush_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_riscv_ex_ctrl.sv
// Self-checking bench for riscv_ex_ctrl: directed scenarios plus random
// stimulus, every cycle compared against a cycle-level behavioural model.
module tb_riscv_ex_ctrl;

    localparam int FLUSH_CYC  = 2;
    localparam int MC_TIMEOUT = 64;
    localparam int CNT_W      = 6;   // small so saturation is reachable
    localparam int CNT_MAX    = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst;
    logic [4:0]       id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd;
    logic [1:0]       ex_src_rd, ex_src_pc;
    logic             mc_req, mc_done, mem_wr, wb_wr;
    logic [1:0]       fwd_a, fwd_b;
    logic             pc_wr_en, if_id_wr_en, if_id_flush, id_ex_wr_en, id_ex_flush, ex_mem_flush, mc_timeout;
    logic [CNT_W-1:0] stall_cnt, flush_cnt;

    riscv_ex_ctrl #(.FLUSH_CYC(FLUSH_CYC), .MC_TIMEOUT(MC_TIMEOUT), .CNT_W(CNT_W)) dut (
        .i_clk(clk), .i_rst(rst),
        .i_ID_rs1(id_rs1), .i_ID_rs2(id_rs2), .i_EX_rs1(ex_rs1), .i_EX_rs2(ex_rs2),
        .i_EX_rd(ex_rd), .i_EX_src_rd(ex_src_rd), .i_EX_src_pc(ex_src_pc),
        .i_EX_mc_req(mc_req), .i_EX_mc_done(mc_done),
        .i_MEM_reg_wr_en(mem_wr), .i_MEM_rd(mem_rd), .i_WB_reg_wr_en(wb_wr), .i_WB_rd(wb_rd),
        .o_EX_fwd_sel_a(fwd_a), .o_EX_fwd_sel_b(fwd_b),
        .o_pc_wr_en(pc_wr_en), .o_IF_ID_wr_en(if_id_wr_en), .o_IF_ID_flush(if_id_flush),
        .o_ID_EX_wr_en(id_ex_wr_en), .o_ID_EX_flush(id_ex_flush), .o_EX_MEM_flush(ex_mem_flush),
        .o_mc_timeout(mc_timeout), .o_stall_cnt(stall_cnt), .o_flush_cnt(flush_cnt)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Model state: remaining wrong-path flush cycles, whether a multi-cycle op
    // is being waited on and for how many cycles, and the two event tallies.
    int m_flush_left = 0;
    bit m_waiting    = 0;
    int m_wait_n     = 0;
    int m_stall      = 0;
    int m_flush      = 0;

    function automatic logic [1:0] fwd(input logic [4:0] rs);
        if (mem_wr && mem_rd != 0 && mem_rd == rs) return 2'd1;
        if (wb_wr && wb_rd != 0 && wb_rd == rs)    return 2'd2;
        return 2'd0;
    endfunction

    // One clock cycle: predict outputs from current inputs, compare mid-cycle,
    // then advance the model across the rising edge.
    task automatic cycle();
        logic [1:0] ea, eb;
        logic [6:0] ectl;   // {pc_wr, ifid_wr, ifid_fl, idex_wr, idex_fl, exmem_fl, timeout}
        int nfl, nwn, st, fl;
        bit nw, lu;
        ea = fwd(ex_rs1);
        eb = fwd(ex_rs2);
        ectl = 7'b1101000;
        nfl = m_flush_left; nw = m_waiting; nwn = m_wait_n; st = m_stall; fl = m_flush;
        lu = ex_src_rd == 2'b01 && ex_rd != 0 && (ex_rd == id_rs1 || ex_rd == id_rs2);
        if (rst) begin
            ea = 0; eb = 0; ectl = 7'b0010110;
            nfl = 0; nw = 0; nwn = 0; st = 0; fl = 0;
        end else if (m_flush_left > 0) begin
            ectl = 7'b1111000;
            nfl--;
        end else if (m_waiting) begin
            nwn = m_wait_n + 1;
            if (mc_done)                nw = 0;
            else if (nwn == MC_TIMEOUT) begin ectl = 7'b1101001; nw = 0; end
            else                        begin ectl = 7'b0000010; st++; end
        end else if (ex_src_pc != 0) begin
            ectl = 7'b1111100; fl++; nfl = FLUSH_CYC - 1;
        end else if (mc_req) begin
            ectl = 7'b0000010; st++; nw = 1; nwn = 0;
        end else if (lu) begin
            ectl = 7'b0001100; st++;
        end
        if (st > CNT_MAX) st = CNT_MAX;
        if (fl > CNT_MAX) fl = CNT_MAX;

        @(negedge clk);
        check("fwd_sel_a", 64'(fwd_a), 64'(ea));
        check("fwd_sel_b", 64'(fwd_b), 64'(eb));
        check("ctrl", 64'({pc_wr_en, if_id_wr_en, if_id_flush, id_ex_wr_en, id_ex_flush, ex_mem_flush, mc_timeout}),
              64'(ectl));
        check("stall_cnt", 64'(stall_cnt), rst ? 64'd0 : 64'(m_stall));
        check("flush_cnt", 64'(flush_cnt), rst ? 64'd0 : 64'(m_flush));

        @(posedge clk);
        #1;
        m_flush_left = nfl; m_waiting = nw; m_wait_n = nwn; m_stall = st; m_flush = fl;
    endtask

    task automatic idle();
        id_rs1 = 0; id_rs2 = 0; ex_rs1 = 0; ex_rs2 = 0; ex_rd = 0; mem_rd = 0; wb_rd = 0;
        ex_src_rd = 0; ex_src_pc = 0; mc_req = 0; mc_done = 0; mem_wr = 0; wb_wr = 0;
    endtask

    initial begin
        idle();
        rst = 1'b1;
        #1;
        repeat (2) cycle();
        rst = 1'b0;
        cycle();

        // Forwarding: MEM beats WB, x0 never forwards, WB path on rs2.
        mem_wr = 1; mem_rd = 5; wb_wr = 1; wb_rd = 5; ex_rs1 = 5;
        cycle();
        check("fwd_mem_wins", 64'(fwd_a), 64'd1);
        mem_rd = 0; wb_rd = 0; ex_rs1 = 0;
        cycle();
        mem_rd = 0; wb_rd = 7; ex_rs2 = 7;
        cycle();
        idle();

        // Load-use: one bubble cycle, then defaults.
        ex_src_rd = 2'b01; ex_rd = 3; id_rs2 = 3;
        cycle();
        idle();
        cycle();
        check("lu_stall_cnt", 64'(stall_cnt), 64'd1);

        // Redirect: two IF/ID flush cycles, ID/EX flush on the first only.
        ex_src_pc = 2'b01;
        cycle();
        cycle();          // redirect seen in FLUSH is ignored
        idle();
        cycle();
        check("redirect_flush_cnt", 64'(flush_cnt), 64'd1);

        // Multi-cycle op done after 5 stall cycles, then release.
        mc_req = 1;
        repeat (5) cycle();
        mc_done = 1;
        cycle();
        idle();
        cycle();
        check("mc_stall_cnt", 64'(stall_cnt), 64'd6);

        // Redirect and mc_req together: redirect wins.
        ex_src_pc = 2'b10; mc_req = 1;
        cycle();
        idle();
        repeat (2) cycle();

        // Timeout: entry + 63 stalled wait cycles, pulse on the 64th.
        mc_req = 1;
        repeat (1 + MC_TIMEOUT) cycle();
        check("timeout_saturated_stall", 64'(stall_cnt), 64'(CNT_MAX));
        idle();
        cycle();

        // Asynchronous reset in the middle of a multi-cycle wait.
        mc_req = 1;
        repeat (3) cycle();
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_ctrl", 64'({pc_wr_en, if_id_flush, id_ex_flush, ex_mem_flush}), 64'b0111);
        check("async_rst_cnt", 64'({stall_cnt, flush_cnt}), 64'd0);
        @(posedge clk);
        #1;
        cycle();
        rst = 1'b0;
        idle();
        cycle();

        // Random traffic with occasional synchronous-looking resets.
        for (int i = 0; i < 3000; i++) begin
            id_rs1    = 5'($urandom_range(0, 3));
            id_rs2    = 5'($urandom_range(0, 3));
            ex_rs1    = 5'($urandom_range(0, 3));
            ex_rs2    = 5'($urandom_range(0, 3));
            ex_rd     = 5'($urandom_range(0, 3));
            mem_rd    = 5'($urandom_range(0, 3));
            wb_rd     = 5'($urandom_range(0, 3));
            mem_wr    = 1'($urandom);
            wb_wr     = 1'($urandom);
            ex_src_rd = 2'($urandom);
            ex_src_pc = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : 2'd0;
            mc_req    = ($urandom_range(0, 5) == 0);
            mc_done   = ($urandom_range(0, 4) == 0);
            rst       = ($urandom_range(0, 299) == 0);
            cycle();
        end
        rst = 1'b0;
        idle();
        cycle();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
